// File: rtl/matrix_coproc_pkg.sv
// Shared opcode, state and saturation definitions for the matrix coprocessor.
// Imported by the ALU and the sequencer.
package matrix_coproc_pkg;

  localparam logic [2:0] OP_ADD   = 3'b000;
  localparam logic [2:0] OP_SUB   = 3'b001;
  localparam logic [2:0] OP_TRANS = 3'b010;
  localparam logic [2:0] OP_MUL_S = 3'b011;
  localparam logic [2:0] OP_NEG   = 3'b100;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_A,
    ST_WAIT_A,
    ST_RD_B,
    ST_WAIT_B,
    ST_EXEC,
    ST_WR,
    ST_DONE
  } state_t;

  function automatic logic op_legal(input logic [2:0] op);
    return op <= OP_NEG;
  endfunction

  function automatic logic op_binary(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

  // Clamp a wide signed value into a w-bit two's complement range.
  function automatic logic signed [63:0] saturate(input logic signed [63:0] v,
                                                  input int unsigned w,
                                                  output logic clipped);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    logic signed [63:0] res;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    clipped = 1'b0;
    res = v;
    if (v > hi) begin
      res = hi;
      clipped = 1'b1;
    end else if (v < lo) begin
      res = lo;
      clipped = 1'b1;
    end
    return res;
  endfunction

endpackage

// File: rtl/matrix_alu.sv
// Combinational element-wise matrix ALU: add, sub, transpose, scalar multiply, negate.
// Arithmetic is done at 64 bits and clamped back to ELEM_W.
module matrix_alu
  import matrix_coproc_pkg::*;
#(
  parameter int N      = 5,
  parameter int ELEM_W = 8,
  parameter int MEM_W  = 256
) (
  input  logic [N*N*ELEM_W-1:0] a,
  input  logic [N*N*ELEM_W-1:0] b,
  input  logic signed [ELEM_W-1:0] scalar,
  input  logic [2:0]            opcode,
  output logic [MEM_W-1:0]      result,
  output logic                  sat
);

  localparam int USED_W = N * N * ELEM_W;

  logic [N*N-1:0] sat_vec;

  generate
    for (genvar gi = 0; gi < N * N; gi++) begin : g_elem
      localparam int ROW  = gi / N;
      localparam int COL  = gi % N;
      localparam int TIDX = COL * N + ROW;

      logic signed [ELEM_W-1:0] a_e;
      logic signed [ELEM_W-1:0] b_e;
      logic signed [ELEM_W-1:0] t_e;
      logic signed [63:0]       full;
      logic signed [63:0]       clamped;
      logic                     clip;

      assign a_e = a[gi*ELEM_W +: ELEM_W];
      assign b_e = b[gi*ELEM_W +: ELEM_W];
      assign t_e = a[TIDX*ELEM_W +: ELEM_W];

      always_comb begin
        full    = '0;
        clip    = 1'b0;
        clamped = '0;
        case (opcode)
          OP_ADD:   full = 64'(a_e) + 64'(b_e);
          OP_SUB:   full = 64'(a_e) - 64'(b_e);
          OP_MUL_S: full = 64'(a_e) * 64'(scalar);
          OP_NEG:   full = -64'(a_e);
          default:  full = '0;
        endcase
        clamped = saturate(full, ELEM_W, clip);
        // Transpose is a pure permutation, so it bypasses the clamp.
        if (opcode == OP_TRANS) begin
          clamped = 64'(t_e);
          clip    = 1'b0;
        end
      end

      assign result[gi*ELEM_W +: ELEM_W] = ELEM_W'(clamped);
      assign sat_vec[gi] = clip;
    end

    if (USED_W < MEM_W) begin : g_pad
      assign result[MEM_W-1:USED_W] = '0;
    end
  endgenerate

  assign sat = |sat_vec;

endmodule

// File: rtl/matrix_coproc_ctrl.sv
// Matrix coprocessor sequencer: fetches A (and B), runs the ALU, writes C back
// to a single-port RAM with RD_LAT read latency, and reports done/err/sat.
module matrix_coproc_ctrl
  import matrix_coproc_pkg::*;
#(
  parameter int N      = 5,
  parameter int ELEM_W = 8,
  parameter int MEM_W  = 256,
  parameter int ADDR_W = 8,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [2:0]        opcode,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [ADDR_W-1:0] addr_b,
  input  logic [ADDR_W-1:0] addr_c,
  input  logic [ELEM_W-1:0] scalar,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              sat,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [MEM_W-1:0]  mem_wdata,
  output logic              mem_wren,
  input  logic [MEM_W-1:0]  mem_rdata
);

  localparam int USED_W = N * N * ELEM_W;
  localparam int CNT_W  = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RD_LAT - 1);

  state_t              state_reg, state_next;
  logic [CNT_W-1:0]    cnt_reg;
  logic [2:0]          op_reg;
  logic [ADDR_W-1:0]   addr_a_reg, addr_b_reg, addr_c_reg;
  logic [ELEM_W-1:0]   scalar_reg;
  logic [USED_W-1:0]   a_reg, b_reg;
  logic [MEM_W-1:0]    result_reg;
  logic                err_reg, sat_reg;
  logic [MEM_W-1:0]    alu_result;
  logic                alu_sat;
  logic                wait_last;

  assign wait_last = (cnt_reg == CNT_LAST);
  assign err       = err_reg;
  assign sat       = sat_reg;

  matrix_alu #(
    .N      (N),
    .ELEM_W (ELEM_W),
    .MEM_W  (MEM_W)
  ) u_alu (
    .a      (a_reg),
    .b      (b_reg),
    .scalar (scalar_reg),
    .opcode (op_reg),
    .result (alu_result),
    .sat    (alu_sat)
  );

  // Memory outputs decode straight from state so a reset kills mem_wren at once.
  always_comb begin
    state_next = state_reg;
    busy       = (state_reg != ST_IDLE);
    done       = 1'b0;
    mem_wren   = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    case (state_reg)
      ST_IDLE: begin
        if (start) state_next = op_legal(opcode) ? ST_RD_A : ST_DONE;
      end
      ST_RD_A: begin
        mem_addr   = addr_a_reg;
        state_next = ST_WAIT_A;
      end
      ST_WAIT_A: begin
        if (wait_last) state_next = op_binary(op_reg) ? ST_RD_B : ST_EXEC;
      end
      ST_RD_B: begin
        mem_addr   = addr_b_reg;
        state_next = ST_WAIT_B;
      end
      ST_WAIT_B: begin
        if (wait_last) state_next = ST_EXEC;
      end
      ST_EXEC: state_next = ST_WR;
      ST_WR: begin
        mem_addr   = addr_c_reg;
        mem_wdata  = result_reg;
        mem_wren   = 1'b1;
        state_next = ST_DONE;
      end
      ST_DONE: begin
        done       = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg  <= ST_IDLE;
      cnt_reg    <= '0;
      op_reg     <= '0;
      addr_a_reg <= '0;
      addr_b_reg <= '0;
      addr_c_reg <= '0;
      scalar_reg <= '0;
      a_reg      <= '0;
      b_reg      <= '0;
      result_reg <= '0;
      err_reg    <= 1'b0;
      sat_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;

      if (state_reg == ST_WAIT_A || state_reg == ST_WAIT_B)
        cnt_reg <= wait_last ? '0 : cnt_reg + 1'b1;
      else
        cnt_reg <= '0;

      if (state_reg == ST_IDLE && start) begin
        op_reg     <= opcode;
        addr_a_reg <= addr_a;
        addr_b_reg <= addr_b;
        addr_c_reg <= addr_c;
        scalar_reg <= scalar;
        err_reg    <= !op_legal(opcode);
        sat_reg    <= 1'b0;
      end

      if (state_reg == ST_WAIT_A && wait_last) a_reg <= mem_rdata[USED_W-1:0];
      if (state_reg == ST_WAIT_B && wait_last) b_reg <= mem_rdata[USED_W-1:0];

      if (state_reg == ST_EXEC) begin
        result_reg <= alu_result;
        sat_reg    <= alu_sat;
      end
    end
  end

endmodule

// File: tb/tb_matrix_coproc_ctrl.sv
// Scoreboard bench for matrix_coproc_ctrl: stimulus queues expectations, a
// monitor pops and checks them on every done pulse.
module tb_matrix_coproc_ctrl;

  localparam int N  = 5;
  localparam int EW = 8;
  localparam int MW = 256;
  localparam int AW = 8;
  localparam logic [2:0] ADD = 3'd0, SUB = 3'd1, TRN = 3'd2, MUL = 3'd3, NEG = 3'd4, ILL = 3'd7;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic          start, start3;
  logic [2:0]    opcode;
  logic [AW-1:0] addr_a, addr_b, addr_c;
  logic [EW-1:0] scalar;

  logic          busy, done, err, sat, mem_wren;
  logic [AW-1:0] mem_addr;
  logic [MW-1:0] mem_wdata, mem_rdata;
  logic          busy3, done3, err3, sat3, mem_wren3;
  logic [AW-1:0] mem_addr3;
  logic [MW-1:0] mem_wdata3, mem_rdata3;

  logic          tb_we;
  logic [AW-1:0] tb_waddr;
  logic [MW-1:0] tb_wdata;

  logic [MW-1:0] ram  [256];
  logic [MW-1:0] ram3 [256];
  logic [MW-1:0] rp;
  logic [MW-1:0] rp3 [3];

  always @(posedge clk) begin
    if (tb_we) ram[tb_waddr] <= tb_wdata;
    else if (mem_wren) ram[mem_addr] <= mem_wdata;
    rp <= ram[mem_addr];
  end

  always @(posedge clk) begin
    if (tb_we) ram3[tb_waddr] <= tb_wdata;
    else if (mem_wren3) ram3[mem_addr3] <= mem_wdata3;
    rp3[0] <= ram3[mem_addr3];
    rp3[1] <= rp3[0];
    rp3[2] <= rp3[1];
  end

  assign mem_rdata  = rp;
  assign mem_rdata3 = rp3[2];

  matrix_coproc_ctrl #(.N(N), .ELEM_W(EW), .MEM_W(MW), .ADDR_W(AW), .RD_LAT(1)) dut (
    .clk(clk), .rst(rst), .start(start), .opcode(opcode),
    .addr_a(addr_a), .addr_b(addr_b), .addr_c(addr_c), .scalar(scalar),
    .busy(busy), .done(done), .err(err), .sat(sat),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wren(mem_wren), .mem_rdata(mem_rdata)
  );

  matrix_coproc_ctrl #(.N(N), .ELEM_W(EW), .MEM_W(MW), .ADDR_W(AW), .RD_LAT(3)) dut3 (
    .clk(clk), .rst(rst), .start(start3), .opcode(opcode),
    .addr_a(addr_a), .addr_b(addr_b), .addr_c(addr_c), .scalar(scalar),
    .busy(busy3), .done(done3), .err(err3), .sat(sat3),
    .mem_addr(mem_addr3), .mem_wdata(mem_wdata3), .mem_wren(mem_wren3), .mem_rdata(mem_rdata3)
  );

  typedef struct {
    logic          err;
    logic          sat;
    int            lat;
    int            wrs;
    logic          chk;
    logic [AW-1:0] ca;
    logic [MW-1:0] word;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [MW-1:0] act, input logic [MW-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic [MW-1:0] fill(input logic [EW-1:0] v);
    logic [MW-1:0] w;
    w = '0;
    for (int k = 0; k < N * N; k++) w[k*EW +: EW] = v;
    return w;
  endfunction

  function automatic logic [MW-1:0] tsrc();
    logic [MW-1:0] w;
    w = '0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) w[(i*N+j)*EW +: EW] = EW'(i * N + j);
    return w;
  endfunction

  function automatic logic [MW-1:0] texp();
    logic [MW-1:0] w;
    w = '0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) w[(i*N+j)*EW +: EW] = EW'(j * N + i);
    return w;
  endfunction

  task automatic expect_op(input logic e_err, input logic e_sat, input int lat, input int wrs,
                           input logic chk, input logic [AW-1:0] ca, input logic [MW-1:0] word);
    exp_t e;
    e.err = e_err; e.sat = e_sat; e.lat = lat; e.wrs = wrs;
    e.chk = chk; e.ca = ca; e.word = word;
    exp_q.push_back(e);
  endtask

  task automatic load(input logic [AW-1:0] a, input logic [MW-1:0] w);
    tb_we = 1'b1; tb_waddr = a; tb_wdata = w;
    @(posedge clk); #1;
    tb_we = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("idle_timeout", MW'(n >= 100), '0);
  endtask

  task automatic issue(input logic [2:0] op, input logic [AW-1:0] a, input logic [AW-1:0] b,
                       input logic [AW-1:0] c, input logic [EW-1:0] sc);
    wait_idle();
    opcode = op; addr_a = a; addr_b = b; addr_c = c; scalar = sc;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain_timeout", MW'(n >= 200), '0);
  endtask

  // Monitor: measures latency and write count, compares against the queue on done.
  initial begin : monitor
    int   cyc;
    int   wrs;
    logic busy_q;
    exp_t e;
    cyc = 0; wrs = 0; busy_q = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        cyc = 0; wrs = 0; busy_q = 1'b0;
      end else begin
        if (busy && !busy_q) begin
          cyc = 1; wrs = 0;
        end else if (busy) begin
          cyc++;
        end
        if (mem_wren) wrs++;
        if (done) begin
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL spurious_done actual=1 required=0");
          end else begin
            e = exp_q.pop_front();
            check("err", MW'(err), MW'(e.err));
            check("sat", MW'(sat), MW'(e.sat));
            check("latency", MW'(cyc), MW'(e.lat));
            check("write_count", MW'(wrs), MW'(e.wrs));
            if (e.chk) check("result_word", ram[e.ca], e.word);
            $display("txn done addr_c=%0d err=%0b sat=%0b cycles=%0d writes=%0d", e.ca, err, sat, cyc, wrs);
          end
        end
        busy_q = busy;
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin : stim
    int n;
    start = 1'b0; start3 = 1'b0; opcode = '0; scalar = '0;
    addr_a = '0; addr_b = '0; addr_c = '0;
    tb_we = 1'b0; tb_waddr = '0; tb_wdata = '0;
    @(posedge clk); #1;
    load(1, fill(8'h03));  load(2, fill(8'h05));
    load(4, fill(8'h80));  load(5, fill(8'h01));
    load(7, fill(8'h7F));  load(8, fill(8'hFF));
    load(10, tsrc());
    load(16, fill(8'h01)); load(17, fill(8'h02));
    load(18, fill(8'hAA));
    check("rst_busy", MW'(busy), '0);
    check("rst_wren", MW'(mem_wren), '0);
    rst = 1'b1;
    @(posedge clk); #1;
    check("reset_busy", MW'(busy), '0);
    check("reset_done", MW'(done), '0);
    check("reset_err", MW'(err), '0);
    check("reset_sat", MW'(sat), '0);
    check("reset_addr", MW'(mem_addr), '0);
    check("reset_wdata", mem_wdata, '0);

    expect_op(1'b0, 1'b0, 7, 1, 1'b1, 3, fill(8'h08));
    issue(ADD, 1, 2, 3, 8'h00);
    drain();
    expect_op(1'b0, 1'b1, 7, 1, 1'b1, 6, fill(8'h80));
    issue(SUB, 4, 5, 6, 8'h00);
    drain();
    expect_op(1'b0, 1'b1, 7, 1, 1'b1, 9, fill(8'h7F));
    issue(SUB, 7, 8, 9, 8'h00);
    drain();
    expect_op(1'b0, 1'b0, 5, 1, 1'b1, 11, texp());
    issue(TRN, 10, 0, 11, 8'h00);
    drain();
    expect_op(1'b0, 1'b0, 5, 1, 1'b1, 12, fill(8'hFA));
    issue(MUL, 1, 0, 12, 8'hFE);
    drain();
    expect_op(1'b0, 1'b1, 5, 1, 1'b1, 13, fill(8'h7F));
    issue(NEG, 4, 0, 13, 8'h00);
    drain();
    repeat (3) @(posedge clk);
    #1;
    check("sat_held", MW'(sat), MW'(1));
    expect_op(1'b1, 1'b0, 1, 0, 1'b0, 0, '0);
    issue(ILL, 1, 2, 3, 8'h00);
    drain();
    repeat (3) @(posedge clk);
    #1;
    check("err_held", MW'(err), MW'(1));

    // start pulse while the B read is in flight must be dropped
    expect_op(1'b0, 1'b0, 7, 1, 1'b1, 14, fill(8'h08));
    issue(ADD, 1, 2, 14, 8'h00);
    @(posedge clk); #1;
    @(posedge clk); #1;
    opcode = ILL; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    drain();

    // start held high: two NEGs separated by exactly one idle cycle
    expect_op(1'b0, 1'b0, 5, 1, 1'b1, 15, fill(8'hFD));
    expect_op(1'b0, 1'b0, 5, 1, 1'b1, 15, fill(8'hFD));
    opcode = NEG; addr_a = 1; addr_c = 15; start = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < 50);
    @(posedge clk); #1;
    check("hold_idle_gap", MW'(busy), '0);
    @(posedge clk); #1;
    check("hold_reaccept", MW'(busy), MW'(1));
    start = 1'b0;
    drain();

    expect_op(1'b0, 1'b0, 7, 1, 1'b1, 16, fill(8'h03));
    issue(ADD, 16, 17, 16, 8'h00);
    drain();

    // reset during the write cycle
    issue(ADD, 1, 2, 18, 8'h00);
    n = 0;
    while (!mem_wren && n < 30) begin
      @(posedge clk); #1;
      n++;
    end
    check("wr_reached", MW'(mem_wren), MW'(1));
    rst = 1'b0;
    #1;
    check("rst_mid_wren", MW'(mem_wren), '0);
    check("rst_mid_busy", MW'(busy), '0);
    check("rst_mid_done", MW'(done), '0);
    @(posedge clk); #3;
    rst = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("rst_mid_word", ram[18], fill(8'hAA));
    check("rst_mid_idle", MW'(busy), '0);

    // RD_LAT=3 instance: binary op completes in cycle 11
    opcode = ADD; addr_a = 1; addr_b = 2; addr_c = 19; start3 = 1'b1;
    @(posedge clk); #1;
    start3 = 1'b0;
    n = 1;
    while (!done3 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    check("lat3_latency", MW'(n), MW'(11));
    check("lat3_err", MW'(err3), '0);
    check("lat3_sat", MW'(sat3), '0);
    @(posedge clk); #1;
    check("lat3_word", ram3[19], fill(8'h08));
    check("lat3_idle", MW'(busy3), '0);
    $display("txn done rd_lat=3 cycles=%0d", n);

    check("queue_empty", MW'(exp_q.size()), '0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/matrix_coproc_ctrl.md
Name: matrix_coproc_ctrl

Overview:
Parametrised matrix coprocessor sequencer, the next generation of the fixed 5x5 add/sub/transpose top level.
- Fetches operand matrix A, and B for binary ops, from a single-port RAM and executes one instruction per start handshake.
- Writes result C back to RAM and reports completion, error and saturation status.
- Supports generic N, element width, memory width and read latency, plus two new ops: scalar multiply and negate, both with signed saturation.

Parameters:
N, 5, matrix dimension (N x N)
ELEM_W, 8, signed element width in bits
MEM_W, 256, RAM word width; must satisfy N*N*ELEM_W <= MEM_W
ADDR_W, 8, RAM address width
RD_LAT, 1, RAM read latency in cycles, >= 1

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous active-low reset
start  in  1  instruction request, sampled only in IDLE
opcode  in  3  operation select
addr_a  in  ADDR_W  RAM address of A
addr_b  in  ADDR_W  RAM address of B
addr_c  in  ADDR_W  RAM address for result
scalar  in  ELEM_W  signed multiplier for MUL_S
busy  out  1  high whenever state != IDLE
done  out  1  one-cycle completion pulse
err  out  1  illegal opcode flag; valid with done, held until next accepted start
sat  out  1  any element saturated; valid with done, held until next accepted start
mem_addr  out  ADDR_W  RAM address
mem_wdata  out  MEM_W  RAM write data
mem_wren  out  1  RAM write enable
mem_rdata  in  MEM_W  RAM read data

Behaviour:
- Element (i,j) occupies bits [(i*N+j)*ELEM_W +: ELEM_W] and is two's complement. Bits above N*N*ELEM_W are written as 0.
- Opcodes: 000 ADD C=A+B; 001 SUB C=A-B; 010 TRANS C(i,j)=A(j,i); 011 MUL_S C=A*scalar; 100 NEG C=-A; 101-111 illegal.
- Arithmetic: compute at full width, then saturate to [-2^(ELEM_W-1), 2^(ELEM_W-1)-1]. sat is the OR over all elements.
- TRANS never saturates. NEG of the minimum value saturates to the maximum and sets sat.
- Reset: state=IDLE, busy=0, done=0, err=0, sat=0, mem_wren=0, mem_addr=0, mem_wdata=0, and all internal operand and result registers are 0.
- IDLE: when start=1, latch opcode, addresses and scalar, clear err and sat, then go to RD_A, or to DONE with err=1 if the opcode is illegal (no memory access).
- RD_A (1 cycle): mem_addr=addr_a, mem_wren=0.
- WAIT_A (RD_LAT cycles): capture mem_rdata into the A register on the last cycle. Binary ops go to RD_B; unary ops (TRANS, MUL_S, NEG) go to EXEC.
- RD_B (1 cycle) and WAIT_B (RD_LAT cycles): same as the A states, using addr_b.
- EXEC (1 cycle): register the ALU result and sat.
- WR (1 cycle): mem_addr=addr_c, mem_wdata=result, mem_wren=1. mem_wren is high in no other state.
- DONE (1 cycle): done=1, then IDLE.
- Latency, counting cycle 1 as the cycle after the edge that accepts start:
  - binary op: done in cycle 5+2*RD_LAT (7 at default)
  - unary op: done in cycle 4+RD_LAT (5 at default)
  - illegal opcode: done in cycle 1
- start while busy is ignored and never queued. start held high through DONE is re-accepted in the following IDLE cycle.
- Input ports are only sampled on acceptance; changes while busy have no effect.
- Aliasing (addr_c equal to addr_a or addr_b) is legal: operands are captured before the write.
- Reset mid-operation: immediate return to IDLE, mem_wren drops asynchronously, no partial write, no done pulse.

Decomposition:
- Shared package matrix_coproc_pkg holds: opcode localparams (OP_ADD, OP_SUB, OP_TRANS, OP_MUL_S, OP_NEG), FSM state encoding, and the saturate function.
- One combinational sub-module, matrix_alu (params N, ELEM_W, MEM_W), takes A, B, scalar and opcode and returns result and sat.
- The FSM, counters and registers stay in matrix_coproc_ctrl.

Test Plan:
- ADD: A all 0x03 at addr 1, B all 0x05 at addr 2, addr_c=3 -> word 3 has all elements 0x08, sat=0, done in cycle 7, exactly one write.
- SUB saturation: A elements 0x80, B elements 0x01 -> all elements 0x80, sat=1; A=0x7F, B=0xFF -> 0x7F, sat=1.
- TRANS then MUL_S: A(i,j)=i*N+j -> C(i,j)=j*N+i with done in cycle 5; MUL_S with scalar=0xFE on A=0x03 -> 0xFA, sat=0.
- NEG and illegal: NEG of 0x80 -> 0x7F with sat=1; opcode 111 -> done in cycle 1, err=1, mem_wren never asserted.
- Handshake: start pulsed during RD_B is ignored; RD_LAT=3 build gives binary done in cycle 11; start held high gives back-to-back instructions with one IDLE cycle between them.
- Reset: rst low during WR -> mem_wren=0 the same cycle, busy=0, result word unchanged, no done pulse.
